// File: rtl/led_display_scheduler.sv
// led_display_scheduler
//   Round-robin scheduler that shares one LED bank between NUM_SRC status sources.
//   A pending source is granted from IDLE. For the one LOAD cycle that follows, the
//   scheduler raises o_led_en and o_src_ack. It then holds the pattern for HOLD_CYCLES
//   unfrozen cycles before it returns to IDLE.
// Ports
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   i_src_req    per-source level request
//   i_src_value  packed source values, source i at [i*LED_WIDTH +: LED_WIDTH]
//   i_freeze     no new grants and hold counter stalls while high
//   o_src_ack    one-hot, one-cycle acknowledge to the granted source
//   o_led_en     one-cycle load strobe for the downstream LED latch
//   o_led_value  value captured at grant time
//   o_cur_src    index of the last granted source
//   o_busy       high in LOAD and HOLD
module led_display_scheduler #(
  parameter int unsigned LED_WIDTH   = 8,
  parameter int unsigned NUM_SRC     = 4,
  parameter int unsigned HOLD_CYCLES = 50000000,
  parameter int unsigned IDX_W       = 2
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_SRC-1:0]             i_src_req,
  input  logic [NUM_SRC*LED_WIDTH-1:0]   i_src_value,
  input  logic                           i_freeze,
  output logic [NUM_SRC-1:0]             o_src_ack,
  output logic                           o_led_en,
  output logic [LED_WIDTH-1:0]           o_led_value,
  output logic [IDX_W-1:0]               o_cur_src,
  output logic                           o_busy
);

  localparam int unsigned CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  typedef enum logic [1:0] {StIdle, StLoad, StHold} state_e;

  state_e               r_state, w_state_d;
  logic [CNT_W-1:0]     r_cnt, w_cnt_d;
  logic [IDX_W-1:0]     r_cur, w_cur_d;
  logic [LED_WIDTH-1:0] r_led_value, w_led_value_d;
  logic [NUM_SRC-1:0]   r_src_ack, w_src_ack_d;
  logic                 r_led_en, w_led_en_d;
  logic                 r_busy, w_busy_d;

  logic                 w_found;
  logic [IDX_W-1:0]     w_pick;
  logic [IDX_W-1:0]     w_cand;

  // Search ptr+1, ptr+2, ... modulo NUM_SRC; the first requester found wins, which
  // puts the last granted source at lowest priority.
  always_comb begin
    w_found = 1'b0;
    w_pick  = '0;
    w_cand  = '0;
    for (int unsigned k = 1; k <= NUM_SRC; k++) begin
      w_cand = IDX_W'((32'(r_cur) + k) % NUM_SRC);
      if (!w_found && i_src_req[w_cand]) begin
        w_found = 1'b1;
        w_pick  = w_cand;
      end
    end
  end

  always_comb begin
    w_state_d     = r_state;
    w_cnt_d       = r_cnt;
    w_cur_d       = r_cur;
    w_led_value_d = r_led_value;
    w_led_en_d    = 1'b0;
    w_src_ack_d   = '0;
    case (r_state)
      StIdle: begin
        if (!i_freeze && w_found) begin
          w_state_d     = StLoad;
          w_cur_d       = w_pick;
          w_led_value_d = i_src_value[32'(w_pick) * LED_WIDTH +: LED_WIDTH];
          w_led_en_d    = 1'b1;
          w_src_ack_d   = NUM_SRC'(1) << w_pick;
        end
      end
      // LOAD ignores i_freeze so the strobe is never stretched.
      StLoad: begin
        w_state_d = StHold;
        w_cnt_d   = CNT_W'(HOLD_CYCLES - 1);
      end
      StHold: begin
        if (!i_freeze) begin
          if (r_cnt == '0) begin
            w_state_d = StIdle;
          end else begin
            w_cnt_d = r_cnt - CNT_W'(1);
          end
        end
      end
      default: w_state_d = StIdle;
    endcase
    w_busy_d = (w_state_d != StIdle);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= StIdle;
      r_cnt       <= '0;
      r_cur       <= IDX_W'(NUM_SRC - 1);
      r_led_value <= '0;
      r_led_en    <= 1'b0;
      r_src_ack   <= '0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_d;
      r_cnt       <= w_cnt_d;
      r_cur       <= w_cur_d;
      r_led_value <= w_led_value_d;
      r_led_en    <= w_led_en_d;
      r_src_ack   <= w_src_ack_d;
      r_busy      <= w_busy_d;
    end
  end

  assign o_src_ack   = r_src_ack;
  assign o_led_en    = r_led_en;
  assign o_led_value = r_led_value;
  assign o_cur_src   = r_cur;
  assign o_busy      = r_busy;

endmodule

// File: tb/tb_led_display_scheduler.sv
module tb_led_display_scheduler;

  localparam int LW = 8;
  localparam int N  = 4;
  localparam int H  = 4;
  localparam int N3 = 3;
  localparam int H3 = 2;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // 4-source instance
  logic [N-1:0]    req;
  logic [N*LW-1:0] val;
  logic            frz;
  logic [N-1:0]    ack;
  logic            en;
  logic [LW-1:0]   led;
  logic [1:0]      cur;
  logic            busy;

  // 3-source instance (non power-of-two wrap)
  logic [N3-1:0]    req3;
  logic [N3*LW-1:0] val3;
  logic             frz3;
  logic [N3-1:0]    ack3;
  logic             en3;
  logic [LW-1:0]    led3;
  logic [1:0]       cur3;
  logic             busy3;

  led_display_scheduler #(
    .LED_WIDTH(LW), .NUM_SRC(N), .HOLD_CYCLES(H), .IDX_W(2)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .i_src_req(req), .i_src_value(val), .i_freeze(frz),
    .o_src_ack(ack), .o_led_en(en), .o_led_value(led), .o_cur_src(cur), .o_busy(busy)
  );

  led_display_scheduler #(
    .LED_WIDTH(LW), .NUM_SRC(N3), .HOLD_CYCLES(H3), .IDX_W(2)
  ) u_dut3 (
    .clk(clk), .rst_n(rst_n), .i_src_req(req3), .i_src_value(val3), .i_freeze(frz3),
    .o_src_ack(ack3), .o_led_en(en3), .o_led_value(led3), .o_cur_src(cur3), .o_busy(busy3)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_out(input string tag, input logic e_en, input logic [3:0] e_ack,
                         input logic [7:0] e_led, input logic [1:0] e_cur, input logic e_busy);
    chk({tag, " led_en"},    32'(en),   32'(e_en));
    chk({tag, " src_ack"},   32'(ack),  32'(e_ack));
    chk({tag, " led_value"}, 32'(led),  32'(e_led));
    chk({tag, " cur_src"},   32'(cur),  32'(e_cur));
    chk({tag, " busy"},      32'(busy), 32'(e_busy));
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Ticks at least once, until led_en is seen or the budget runs out.
  task automatic wait_en(input string name, input int maxc, output int cyc);
    cyc = 0;
    do begin
      tick();
      cyc++;
    end while (!en && cyc < maxc);
    chk({name, " led_en seen"}, 32'(en), 32'd1);
  endtask

  task automatic wait_en3(input string name, input int maxc);
    int cyc;
    cyc = 0;
    do begin
      tick();
      cyc++;
    end while (!en3 && cyc < maxc);
    chk({name, " led_en seen"}, 32'(en3), 32'd1);
  endtask

  // Behavioural model: m_rem counts cycles until IDLE; the LOAD cycle always elapses,
  // hold cycles only elapse while unfrozen.
  int         m_rem;
  logic [1:0] m_cur;
  logic       m_en;
  logic [3:0] m_ack;
  logic [7:0] m_led;

  task automatic model_reset();
    m_rem = 0; m_cur = 2'(N - 1); m_en = 1'b0; m_ack = '0; m_led = '0;
  endtask

  task automatic model_step();
    m_en  = 1'b0;
    m_ack = '0;
    if (m_rem == 0) begin
      if (!frz && req != '0) begin
        for (int k = 1; k <= N; k++) begin
          int j;
          j = (int'(m_cur) + k) % N;
          if (req[j]) begin
            m_cur = 2'(j);
            break;
          end
        end
        m_led = val[int'(m_cur) * LW +: LW];
        m_en  = 1'b1;
        m_ack = 4'(1) << m_cur;
        m_rem = H + 1;
      end
    end else if (m_rem == H + 1) begin
      m_rem--;
    end else if (!frz) begin
      m_rem--;
    end
  endtask

  typedef struct {
    logic [3:0] req;
    logic       frz;
    logic       en;
    logic [3:0] ack;
    logic [7:0] led;
    logic [1:0] cur;
    logic       busy;
  } vec_t;

  vec_t tbl[14];

  initial begin
    logic [7:0] byt[4];
    int order[5];
    int cyc;
    int c;

    byt[0] = 8'h11; byt[1] = 8'h22; byt[2] = 8'hA5; byt[3] = 8'h44;
    order[0] = 0; order[1] = 1; order[2] = 2; order[3] = 3; order[4] = 0;

    // Single requester 2, then all four with one frozen hold cycle.
    tbl[0]  = '{4'b0100, 1'b0, 1'b1, 4'b0100, 8'hA5, 2'd2, 1'b1};
    tbl[1]  = '{4'b0100, 1'b0, 1'b0, 4'b0000, 8'hA5, 2'd2, 1'b1};
    tbl[2]  = '{4'b0100, 1'b0, 1'b0, 4'b0000, 8'hA5, 2'd2, 1'b1};
    tbl[3]  = '{4'b0100, 1'b0, 1'b0, 4'b0000, 8'hA5, 2'd2, 1'b1};
    tbl[4]  = '{4'b0100, 1'b0, 1'b0, 4'b0000, 8'hA5, 2'd2, 1'b1};
    tbl[5]  = '{4'b0100, 1'b0, 1'b0, 4'b0000, 8'hA5, 2'd2, 1'b0};
    tbl[6]  = '{4'b0100, 1'b0, 1'b1, 4'b0100, 8'hA5, 2'd2, 1'b1};
    tbl[7]  = '{4'b1111, 1'b0, 1'b0, 4'b0000, 8'hA5, 2'd2, 1'b1};
    tbl[8]  = '{4'b1111, 1'b1, 1'b0, 4'b0000, 8'hA5, 2'd2, 1'b1};
    tbl[9]  = '{4'b1111, 1'b0, 1'b0, 4'b0000, 8'hA5, 2'd2, 1'b1};
    tbl[10] = '{4'b1111, 1'b0, 1'b0, 4'b0000, 8'hA5, 2'd2, 1'b1};
    tbl[11] = '{4'b1111, 1'b0, 1'b0, 4'b0000, 8'hA5, 2'd2, 1'b1};
    tbl[12] = '{4'b1111, 1'b0, 1'b0, 4'b0000, 8'hA5, 2'd2, 1'b0};
    tbl[13] = '{4'b1111, 1'b0, 1'b1, 4'b1000, 8'h44, 2'd3, 1'b1};

    // Reset held with every source requesting
    rst_n = 1'b0;
    req = 4'hF; frz = 1'b0; val = {8'h44, 8'hA5, 8'h22, 8'h11};
    req3 = 3'b111; frz3 = 1'b0; val3 = {8'hC3, 8'hB2, 8'hA1};
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("reset led_en", 32'(en), 32'd0);
    end
    chk_out("reset", 1'b0, 4'b0000, 8'h00, 2'd3, 1'b0);
    chk("reset cur_src n3", 32'(cur3), 32'd2);
    chk("reset led_en n3", 32'(en3), 32'd0);
    req = '0; req3 = '0;
    rst_n = 1'b1;
    tick();
    chk_out("idle no req", 1'b0, 4'b0000, 8'h00, 2'd3, 1'b0);

    // Vector table
    for (int i = 0; i < 14; i++) begin
      req = tbl[i].req;
      frz = tbl[i].frz;
      tick();
      chk_out($sformatf("vec%0d", i), tbl[i].en, tbl[i].ack, tbl[i].led, tbl[i].cur,
              tbl[i].busy);
    end

    // Fairness from reset: 0,1,2,3,0
    rst_n = 1'b0; req = 4'hF; frz = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int g = 0; g < 5; g++) begin
      wait_en("rr", 20, cyc);
      chk($sformatf("rr%0d cur_src", g), 32'(cur), 32'(order[g]));
      chk($sformatf("rr%0d led_value", g), 32'(led), 32'(byt[order[g]]));
      chk($sformatf("rr%0d spacing", g), 32'(cyc), 32'((g == 0) ? 1 : H + 2));
    end

    // Freeze 3 cycles mid-HOLD delays the next grant by 3
    req = 4'b0001;
    tick();
    chk("load exit led_en", 32'(en), 32'd0);
    chk("load exit src_ack", 32'(ack), 32'd0);
    tick();
    frz = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("frozen hold busy", 32'(busy), 32'd1);
    end
    frz = 1'b0;
    wait_en("after freeze", 20, cyc);
    chk("freeze delay", 32'(cyc + 5), 32'(H + 2 + 3));
    chk("freeze grant cur", 32'(cur), 32'd0);

    // Freeze during LOAD does not stretch the strobe
    frz = 1'b1;
    tick();
    chk("freeze load led_en", 32'(en), 32'd0);
    chk("freeze load src_ack", 32'(ack), 32'd0);
    chk("freeze load busy", 32'(busy), 32'd1);
    frz = 1'b0;
    req = '0;
    c = 0;
    while (busy && c < 20) begin
      tick();
      c++;
    end
    chk("idle reached", 32'(busy), 32'd0);

    // Freeze in IDLE with pending request blocks the grant
    frz = 1'b1; req = 4'b0010;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("frozen idle led_en", 32'(en), 32'd0);
    end
    frz = 1'b0;
    tick();
    chk_out("unfreeze grant", 1'b1, 4'b0010, 8'h22, 2'd1, 1'b1);

    // Value change during HOLD, then asynchronous reset mid-HOLD
    req = '0;
    tick();
    val[15:8] = 8'h5A;
    tick();
    tick();
    chk("hold value kept", 32'(led), 32'h22);
    chk("hold busy", 32'(busy), 32'd1);
    #2 rst_n = 1'b0;
    #1 chk_out("async reset", 1'b0, 4'b0000, 8'h00, 2'd3, 1'b0);
    tick();
    chk("reset held led_en", 32'(en), 32'd0);

    // Three sources: from last grant 2, 3'b101 wraps to 0 then 2; 3'b010 then gives 1
    req3 = 3'b100;
    rst_n = 1'b1;
    wait_en3("n3 first", 10);
    chk("n3 first cur", 32'(cur3), 32'd2);
    chk("n3 first ack", 32'(ack3), 32'b100);
    req3 = 3'b101;
    wait_en3("n3 wrap", 10);
    chk("n3 wrap cur", 32'(cur3), 32'd0);
    chk("n3 wrap value", 32'(led3), 32'hA1);
    wait_en3("n3 next", 10);
    chk("n3 next cur", 32'(cur3), 32'd2);
    req3 = 3'b010;
    wait_en3("n3 skip", 10);
    chk("n3 skip cur", 32'(cur3), 32'd1);
    chk("n3 skip value", 32'(led3), 32'hB2);
    req3 = '0;

    // Randomized run against the model
    rst_n = 1'b0; req = '0; frz = 1'b0;
    tick();
    model_reset();
    rst_n = 1'b1;
    for (int i = 0; i < 600; i++) begin
      req = ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
      frz = ($urandom_range(0, 5) == 0);
      val = $urandom;
      @(posedge clk);
      model_step();
      @(negedge clk);
      chk_out($sformatf("rand%0d", i), m_en, m_ack, m_led, m_cur, (m_rem != 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
